// File: rtl/aes_enc_stream_if.sv
// Streaming interface for the AES-128 encryption engine.
// master drives plaintext, key/IV context and sink ready; slave is the engine.
interface aes_enc_stream_if #(
    parameter int unsigned CNT_W = 16
);
    // Plaintext side
    logic             in_valid;
    logic             in_ready;
    logic             in_first;
    logic [127:0]     in_data;
    logic [127:0]     key;
    logic [127:0]     iv;
    // Ciphertext side
    logic             out_valid;
    logic             out_ready;
    logic [127:0]     out_data;
    // Status
    logic             busy;
    logic [CNT_W-1:0] blk_count;

    modport master (
        output in_valid,
        output in_first,
        output in_data,
        output key,
        output iv,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  busy,
        input  blk_count
    );

    modport slave (
        input  in_valid,
        input  in_first,
        input  in_data,
        input  key,
        input  iv,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output busy,
        output blk_count
    );
endinterface

// File: rtl/aes_enc_stream.sv
// Iterative AES-128 encryption engine, one round per clock, valid/ready on both
// sides, ECB (MODE=0) or CBC (MODE=1) chaining with an internally held key/IV.
// The interface instance must be built with the same CNT_W as this module.
module aes_enc_stream #(
    parameter int unsigned MODE  = 0,
    parameter int unsigned CNT_W = 16
) (
    input logic             clk,
    input logic             reset,
    aes_enc_stream_if.slave bus
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRound = 2'd1;
    localparam logic [1:0] StHold  = 2'd2;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
        8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
        8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
        8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
        8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
        8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
        8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
        8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
        8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
        8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
        8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
        8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
        8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
        8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
        8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
        8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
        8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Byte n of a block (FIPS-197 order) lives at bits [127-8n -: 8].
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        case (rnd)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) begin
            o[8*i +: 8] = SBOX[s[8*i +: 8]];
        end
        return o;
    endfunction

    // Row r of column c takes the byte from column (c + r) mod 4.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                o[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c + r) % 4)) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            o[127 - 32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119 - 32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111 - 32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103 - 32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    // One step of the AES-128 key schedule: four words in, next four out.
    function automatic logic [127:0] expand_key(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        w0 = k[127:96];
        w1 = k[95:64];
        w2 = k[63:32];
        w3 = k[31:0];
        t  = {SBOX[w3[23:16]], SBOX[w3[15:8]], SBOX[w3[7:0]], SBOX[w3[31:24]]} ^ {rc, 24'h0};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    logic [1:0]       r_st;
    logic [127:0]     r_key;
    logic [127:0]     r_chain;
    logic [127:0]     r_blk;
    logic [127:0]     r_rk;
    logic [3:0]       r_round;
    logic [127:0]     r_out_data;
    logic             r_out_valid;
    logic [CNT_W-1:0] r_cnt;

    logic [1:0]       w_st_nxt;
    logic [127:0]     w_key_nxt;
    logic [127:0]     w_chain_nxt;
    logic [127:0]     w_blk_nxt;
    logic [127:0]     w_rk_nxt;
    logic [3:0]       w_round_nxt;
    logic [127:0]     w_out_data_nxt;
    logic             w_out_valid_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;

    logic             w_in_ready;
    logic [127:0]     w_k0;
    logic [127:0]     w_pre;
    logic [127:0]     w_rk_step;
    logic [127:0]     w_sr;
    logic [127:0]     w_round_out;

    // Datapath for the round in flight and the whitening of an incoming block
    always_comb begin
        w_k0        = bus.in_first ? bus.key : r_key;
        w_pre       = bus.in_data;
        if (MODE == 1) begin
            w_pre = bus.in_data ^ (bus.in_first ? bus.iv : r_chain);
        end
        w_rk_step   = expand_key(r_rk, rcon(r_round));
        w_sr        = shift_rows(sub_bytes(r_blk));
        w_round_out = ((r_round == 4'd10) ? w_sr : mix_columns(w_sr)) ^ w_rk_step;
    end

    // Next-state logic for the IDLE -> ROUND -> HOLD sequence
    always_comb begin
        w_st_nxt        = r_st;
        w_key_nxt       = r_key;
        w_chain_nxt     = r_chain;
        w_blk_nxt       = r_blk;
        w_rk_nxt        = r_rk;
        w_round_nxt     = r_round;
        w_out_data_nxt  = r_out_data;
        w_out_valid_nxt = r_out_valid;
        w_cnt_nxt       = r_cnt;
        case (r_st)
            StIdle: begin
                if (bus.in_valid) begin
                    if (bus.in_first) begin
                        w_key_nxt = bus.key;
                        w_cnt_nxt = '0;
                        if (MODE == 1) begin
                            w_chain_nxt = bus.iv;
                        end
                    end
                    w_blk_nxt   = w_pre ^ w_k0;
                    w_rk_nxt    = w_k0;
                    w_round_nxt = 4'd1;
                    w_st_nxt    = StRound;
                end
            end
            StRound: begin
                w_rk_nxt    = w_rk_step;
                w_blk_nxt   = w_round_out;
                w_round_nxt = r_round + 4'd1;
                if (r_round == 4'd10) begin
                    w_out_data_nxt  = w_round_out;
                    w_out_valid_nxt = 1'b1;
                    w_st_nxt        = StHold;
                    if (MODE == 1) begin
                        w_chain_nxt = w_round_out;
                    end
                end
            end
            StHold: begin
                if (bus.out_ready) begin
                    w_out_valid_nxt = 1'b0;
                    w_cnt_nxt       = r_cnt + CNT_W'(1);
                    w_st_nxt        = StIdle;
                end
            end
            default: begin
                w_st_nxt = StIdle;
            end
        endcase
    end

    // State registers; an asynchronous reset drops any partial block
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_st        <= StIdle;
            r_key       <= '0;
            r_chain     <= '0;
            r_blk       <= '0;
            r_rk        <= '0;
            r_round     <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_st        <= w_st_nxt;
            r_key       <= w_key_nxt;
            r_chain     <= w_chain_nxt;
            r_blk       <= w_blk_nxt;
            r_rk        <= w_rk_nxt;
            r_round     <= w_round_nxt;
            r_out_data  <= w_out_data_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_cnt       <= w_cnt_nxt;
        end
    end

    assign w_in_ready    = (r_st == StIdle);
    assign bus.in_ready  = w_in_ready;
    assign bus.busy      = ~w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.blk_count = r_cnt;

endmodule

// File: tb/tb_aes_enc_stream.sv
// Self-checking bench: an ECB engine (CNT_W=2) and a CBC engine (CNT_W=16) share
// stimulus; tb_sel picks the engine under test. Expected ciphertext comes from
// a byte-array AES model whose S-box is derived from GF(2^8) inversion.
module tb_aes_enc_stream;

    logic         clk;
    logic         rst_n;
    logic         tb_sel;
    logic         tb_valid;
    logic         tb_first;
    logic         tb_out_ready;
    logic [127:0] tb_data;
    logic [127:0] tb_key;
    logic [127:0] tb_iv;

    int errors;
    int checks;

    logic [7:0]   m_sbox [256];
    logic [127:0] m_key   [2];
    logic [127:0] m_chain [2];
    int           m_cnt   [2];

    aes_enc_stream_if #(.CNT_W(2))  ecb_if ();
    aes_enc_stream_if #(.CNT_W(16)) cbc_if ();

    aes_enc_stream #(.MODE(0), .CNT_W(2)) u_ecb (
        .clk   (clk),
        .reset (rst_n),
        .bus   (ecb_if)
    );

    aes_enc_stream #(.MODE(1), .CNT_W(16)) u_cbc (
        .clk   (clk),
        .reset (rst_n),
        .bus   (cbc_if)
    );

    assign ecb_if.in_valid  = tb_valid && !tb_sel;
    assign cbc_if.in_valid  = tb_valid && tb_sel;
    assign ecb_if.in_first  = tb_first;
    assign cbc_if.in_first  = tb_first;
    assign ecb_if.in_data   = tb_data;
    assign cbc_if.in_data   = tb_data;
    assign ecb_if.key       = tb_key;
    assign cbc_if.key       = tb_key;
    assign ecb_if.iv        = tb_iv;
    assign cbc_if.iv        = tb_iv;
    assign ecb_if.out_ready = tb_sel ? 1'b1 : tb_out_ready;
    assign cbc_if.out_ready = tb_sel ? tb_out_ready : 1'b1;

    logic         w_in_ready;
    logic         w_out_valid;
    logic         w_busy;
    logic [127:0] w_out_data;
    logic [15:0]  w_cnt;

    assign w_in_ready  = tb_sel ? cbc_if.in_ready  : ecb_if.in_ready;
    assign w_out_valid = tb_sel ? cbc_if.out_valid : ecb_if.out_valid;
    assign w_busy      = tb_sel ? cbc_if.busy      : ecb_if.busy;
    assign w_out_data  = tb_sel ? cbc_if.out_data  : ecb_if.out_data;
    assign w_cnt       = tb_sel ? cbc_if.blk_count : {14'd0, ecb_if.blk_count};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] b;
        for (int v = 0; v < 256; v++) begin
            b   = 8'(v);
            inv = 8'h00;
            if (v != 0) begin
                inv = 8'h01;
                for (int k = 0; k < 254; k++) inv = gmul(inv, b);
            end
            m_sbox[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [127:0] pt);
        logic [7:0]   ks [176];
        logic [7:0]   st [16];
        logic [7:0]   tmp [16];
        logic [7:0]   t [4];
        logic [7:0]   rc;
        logic [7:0]   x;
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) begin
            ks[i] = key[127 - 8*i -: 8];
            st[i] = pt[127 - 8*i -: 8];
        end
        rc = 8'h01;
        for (int i = 16; i < 176; i += 4) begin
            for (int j = 0; j < 4; j++) t[j] = ks[i - 4 + j];
            if (i % 16 == 0) begin
                x    = t[0];
                t[0] = m_sbox[t[1]] ^ rc;
                t[1] = m_sbox[t[2]];
                t[2] = m_sbox[t[3]];
                t[3] = m_sbox[x];
                rc   = gmul(rc, 8'h02);
            end
            for (int j = 0; j < 4; j++) ks[i + j] = ks[i - 16 + j] ^ t[j];
        end
        for (int i = 0; i < 16; i++) st[i] = st[i] ^ ks[i];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) st[i] = m_sbox[st[i]];
            for (int row = 0; row < 4; row++)
                for (int col = 0; col < 4; col++)
                    tmp[row + 4*col] = st[row + 4*((col + row) % 4)];
            for (int c = 0; c < 4; c++) begin
                a0 = tmp[4*c];
                a1 = tmp[4*c + 1];
                a2 = tmp[4*c + 2];
                a3 = tmp[4*c + 3];
                if (r < 10) begin
                    st[4*c]     = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    st[4*c + 1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    st[4*c + 2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    st[4*c + 3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end else begin
                    st[4*c]     = a0;
                    st[4*c + 1] = a1;
                    st[4*c + 2] = a2;
                    st[4*c + 3] = a3;
                end
            end
            for (int i = 0; i < 16; i++) st[i] = st[i] ^ ks[16*r + i];
        end
        for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = st[i];
        return res;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic wait_idle();
        int n;
        n = 0;
        while (!w_in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("in_ready_wait", 128'(w_in_ready), 128'd1);
    endtask

    task automatic accept(input bit first, input logic [127:0] data,
                          input logic [127:0] key, input logic [127:0] iv);
        @(negedge clk);
        tb_first = first;
        tb_data  = data;
        tb_key   = key;
        tb_iv    = iv;
        tb_valid = 1'b1;
        @(posedge clk);
        #1;
        tb_valid = 1'b0;
        tb_first = 1'b0;
        tb_key   = rnd128();
        tb_iv    = rnd128();
    endtask

    // One full block through the selected engine; kat overrides the model when given.
    task automatic run_block(input bit first, input logic [127:0] data, input logic [127:0] key,
                             input logic [127:0] iv, input int stall, input bit use_kat,
                             input logic [127:0] kat);
        logic [127:0] exp;
        logic [127:0] pre;
        int           s;
        int           n;
        int           cnt_before;
        s = tb_sel ? 1 : 0;
        if (first) begin
            m_key[s] = key;
            m_cnt[s] = 0;
            if (s == 1) m_chain[s] = iv;
        end
        cnt_before = m_cnt[s];
        pre = (s == 1) ? (data ^ m_chain[s]) : data;
        exp = use_kat ? kat : aes_ref(m_key[s], pre);
        if (s == 1) m_chain[s] = exp;
        m_cnt[s] = (m_cnt[s] + 1) % ((s == 1) ? 65536 : 4);

        wait_idle();
        tb_out_ready = (stall == 0);
        accept(first, data, key, iv);
        check_eq("busy_after_accept", {127'd0, w_busy}, 128'd1);
        check_eq("in_ready_after_accept", {127'd0, w_in_ready}, 128'd0);
        check_eq("cnt_after_accept", 128'(w_cnt), 128'(cnt_before));

        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!w_out_valid && n < 16);
        check_eq("latency", 128'(n), 128'd10);
        check_eq("out_data", w_out_data, exp);
        check_eq("ready_valid_excl", {127'd0, w_in_ready}, 128'd0);

        for (int i = 0; i < stall; i++) begin
            tb_valid = 1'($urandom_range(0, 1));
            tb_first = 1'b1;
            tb_data  = rnd128();
            @(posedge clk);
            #1;
            check_eq("hold_data", w_out_data, exp);
            check_eq("hold_valid", {127'd0, w_out_valid}, 128'd1);
            check_eq("hold_in_ready", {127'd0, w_in_ready}, 128'd0);
        end
        tb_valid     = 1'b0;
        tb_first     = 1'b0;
        tb_out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_eq("valid_after_hs", {127'd0, w_out_valid}, 128'd0);
        check_eq("in_ready_after_hs", {127'd0, w_in_ready}, 128'd1);
        check_eq("busy_after_hs", {127'd0, w_busy}, 128'd0);
        check_eq("blk_count", 128'(w_cnt), 128'(m_cnt[s]));
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_ecb_ready"}, {127'd0, ecb_if.in_ready}, 128'd1);
        check_eq({tag, "_ecb_valid"}, {127'd0, ecb_if.out_valid}, 128'd0);
        check_eq({tag, "_ecb_busy"}, {127'd0, ecb_if.busy}, 128'd0);
        check_eq({tag, "_ecb_data"}, ecb_if.out_data, 128'd0);
        check_eq({tag, "_ecb_cnt"}, 128'(ecb_if.blk_count), 128'd0);
        check_eq({tag, "_cbc_ready"}, {127'd0, cbc_if.in_ready}, 128'd1);
        check_eq({tag, "_cbc_data"}, cbc_if.out_data, 128'd0);
        check_eq({tag, "_cbc_cnt"}, 128'(cbc_if.blk_count), 128'd0);
    endtask

    localparam logic [127:0] KeyB  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PtB   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CtB   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KeyC  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PtC   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CtC   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] Pt1   = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] Pt2   = 128'hae2d8a571e03ac9c9eb76fac45af8e51;

    initial begin
        errors       = 0;
        checks       = 0;
        rst_n        = 1'b0;
        tb_sel       = 1'b0;
        tb_valid     = 1'b0;
        tb_first     = 1'b0;
        tb_out_ready = 1'b1;
        tb_data      = '0;
        tb_key       = '0;
        tb_iv        = '0;
        for (int i = 0; i < 2; i++) begin
            m_key[i]   = '0;
            m_chain[i] = '0;
            m_cnt[i]   = 0;
        end
        build_sbox();
        #1;
        check_reset_vals("reset");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // First block after reset without in_first runs under an all-zero key
        tb_sel = 1'b0;
        run_block(1'b0, rnd128(), rnd128(), rnd128(), 0, 1'b0, '0);
        // FIPS-197 appendix B and C.1
        run_block(1'b1, PtB, KeyB, rnd128(), 0, 1'b1, CtB);
        run_block(1'b1, PtC, KeyC, rnd128(), 0, 1'b1, CtC);
        run_block(1'b1, PtB, KeyB, rnd128(), 0, 1'b1, CtB);
        run_block(1'b0, Pt1, rnd128(), rnd128(), 0, 1'b1,
                  128'h3ad77bb40d7a3660a89ecaf32466ef97);

        // SP800-38A CBC
        tb_sel = 1'b1;
        run_block(1'b1, Pt1, KeyB, KeyC, 0, 1'b1, 128'h7649abac8119b246cee98e9b12e9197d);
        run_block(1'b0, Pt2, rnd128(), rnd128(), 0, 1'b1, 128'h5086cb9b507219ee95db113a917678b2);

        // Backpressure, then a chained block proves stray in_valid pulses were ignored
        tb_sel = 1'b0;
        run_block(1'b0, rnd128(), rnd128(), rnd128(), 7, 1'b0, '0);
        run_block(1'b0, Pt1, rnd128(), rnd128(), 0, 1'b1, 128'h3ad77bb40d7a3660a89ecaf32466ef97);

        // Counter wrap on the 2-bit engine: 1,2,3,0,1 then cleared by in_first
        run_block(1'b1, rnd128(), rnd128(), rnd128(), 0, 1'b0, '0);
        for (int i = 0; i < 4; i++) run_block(1'b0, rnd128(), rnd128(), rnd128(), 0, 1'b0, '0);
        run_block(1'b1, rnd128(), rnd128(), rnd128(), 1, 1'b0, '0);

        // Reset during round 5 of a block
        wait_idle();
        accept(1'b0, PtB, rnd128(), rnd128());
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("midreset");
        for (int i = 0; i < 2; i++) begin
            m_key[i]   = '0;
            m_chain[i] = '0;
            m_cnt[i]   = 0;
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_block(1'b1, PtB, KeyB, rnd128(), 0, 1'b1, CtB);

        // Randomized traffic on both engines
        for (int i = 0; i < 24; i++) begin
            tb_sel = 1'($urandom_range(0, 1));
            run_block(($urandom_range(0, 3) == 0), rnd128(), rnd128(), rnd128(),
                      int'($urandom_range(0, 3)), 1'b0, '0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
